// File: rtl/variable_delay_line.sv
// Runtime-programmable delay line: circular buffer with a trailing read tap.
// Ports: i_CLK, i_RST_N, i_ENABLE, i_DELAY, i_VALID, i_DATA -> o_VALID, o_DATA, o_SETTLED, o_DELAY.
module variable_delay_line #(
  parameter int W_DATA    = 8,
  parameter int MAX_DELAY = 16,
  parameter int W_DLY     = 5
) (
  input  logic              i_CLK,
  input  logic              i_RST_N,
  input  logic              i_ENABLE,
  input  logic [W_DLY-1:0]  i_DELAY,
  input  logic              i_VALID,
  input  logic [W_DATA-1:0] i_DATA,
  output logic              o_VALID,
  output logic [W_DATA-1:0] o_DATA,
  output logic              o_SETTLED,
  output logic [W_DLY-1:0]  o_DELAY
);

  localparam int W_PTR = (MAX_DELAY > 1) ? $clog2(MAX_DELAY) : 1;
  localparam logic [W_DLY-1:0] L_MAX = W_DLY'(MAX_DELAY);
  localparam logic [W_PTR-1:0] L_TOP = W_PTR'(MAX_DELAY - 1);

  logic [W_DATA-1:0] r_mem [MAX_DELAY];
  logic [MAX_DELAY-1:0] r_vmem;
  logic [W_PTR-1:0]  r_wp;
  logic [W_DLY-1:0]  r_dly;
  logic [W_DLY-1:0]  r_cnt;
  logic              r_settled;
  logic [W_DATA-1:0] r_data;
  logic              r_valid;

  logic [W_DLY-1:0]  w_eff;
  logic              w_chg;
  logic [W_PTR-1:0]  w_back;
  logic [W_PTR-1:0]  w_rd;
  logic [W_DATA-1:0] w_tap_data;
  logic              w_tap_vld;
  logic [W_DLY-1:0]  w_cnt_nxt;
  logic              w_settled_nxt;

  always_comb begin
    w_eff = i_DELAY;
    if (i_DELAY == '0)
      w_eff = W_DLY'(1);
    else if (i_DELAY > L_MAX)
      w_eff = L_MAX;
  end

  assign w_chg = (w_eff != r_dly);

  // Tap trails the write pointer by D-1 entries; the sample written
  // D-1 edges ago is read on this edge, giving D register stages total.
  assign w_back = W_PTR'(r_dly - W_DLY'(1));
  assign w_rd   = (r_wp >= w_back) ? (r_wp - w_back)
                : W_PTR'(r_wp + W_PTR'(MAX_DELAY) - w_back);

  // D=1 bypasses the buffer and is just the output register.
  always_comb begin
    w_tap_data = r_mem[w_rd];
    w_tap_vld  = r_vmem[w_rd];
    if (r_dly == W_DLY'(1)) begin
      w_tap_data = i_DATA;
      w_tap_vld  = i_VALID;
    end
  end

  always_comb begin
    w_cnt_nxt     = r_cnt;
    w_settled_nxt = r_settled;
    if (w_chg) begin
      w_cnt_nxt     = w_eff;
      w_settled_nxt = 1'b0;
    end else if (r_cnt != '0) begin
      w_cnt_nxt     = r_cnt - W_DLY'(1);
      w_settled_nxt = (r_cnt == W_DLY'(1));
    end
  end

  always_ff @(posedge i_CLK) begin
    if (i_ENABLE)
      r_mem[r_wp] <= i_DATA;
  end

  always_ff @(posedge i_CLK) begin
    if (!i_RST_N) begin
      r_wp      <= '0;
      r_vmem    <= '0;
      r_dly     <= W_DLY'(1);
      r_cnt     <= '0;
      r_settled <= 1'b1;
      r_data    <= '0;
      r_valid   <= 1'b0;
    end else if (i_ENABLE) begin
      r_wp         <= (r_wp == L_TOP) ? '0 : r_wp + W_PTR'(1);
      r_vmem[r_wp] <= i_VALID;
      r_dly        <= w_eff;
      r_cnt        <= w_cnt_nxt;
      r_settled    <= w_settled_nxt;
      r_data       <= w_tap_data;
      r_valid      <= w_tap_vld & w_settled_nxt;
    end
  end

  assign o_DATA    = r_data;
  assign o_VALID   = r_valid;
  assign o_SETTLED = r_settled;
  assign o_DELAY   = r_dly;

endmodule

// File: doc/variable_delay_line.md
Name: variable_delay_line

Overview:
- Runtime-programmable delay line for a data word plus its valid flag. Delay is set in clock cycles, from 1 to MAX_DELAY.
- Built as a circular buffer with a write pointer and a trailing read tap. It is the readout end of a delay store, not a fixed register chain.
- Used where the realignment latency between datapath branches is only known at run time, for example from a control register.
- Delivers retimed data once the selected delay has settled, and flags stale buffer contents after every delay change.

Parameters:
- W_DATA, 8, data bit width.
- MAX_DELAY, 16, largest supported delay in cycles (>=2). The buffer holds MAX_DELAY entries.
- W_DLY, 5, width of the delay-select port; must satisfy 2^W_DLY > MAX_DELAY.

Ports:
- Clock  input  1  rising-edge clock.
- Reset  input  1  synchronous reset, active-low (0 = reset).
- i_ENABLE  input  1  clock enable; 0 freezes the whole block.
- i_DELAY  input  W_DLY  requested delay in cycles.
- i_VALID  input  1  valid flag travelling with i_DATA.
- i_DATA  input  W_DATA  data in.
- o_VALID  output  1  delayed valid, masked while settling.
- o_DATA  output  W_DATA  delayed data, registered.
- o_SETTLED  output  1  1 = output reflects the current delay.
- o_DELAY  output  W_DLY  delay currently in effect, after clamping.

Behaviour:
- Reset (Reset=0 at a rising edge): write pointer=0, all stored valid bits=0, o_DATA=0, o_VALID=0, o_DELAY=1, settle counter=0, o_SETTLED=1. Stored data words need no reset. Reset overrides i_ENABLE.
- Clamping: i_DELAY=0 -> 1; i_DELAY>MAX_DELAY -> MAX_DELAY. The clamped value is eff_dly.
- Latency: with i_ENABLE=1 and o_DELAY=D, the sample on i_DATA/i_VALID at edge k appears on o_DATA/raw valid after edge k+D-1. This is exactly D register stages, identical to a D-stage shift chain.
- D=1 is a pure output register (bypass of the buffer). D=MAX_DELAY uses every entry.
- Pointer: increments once per enabled cycle and wraps from MAX_DELAY-1 to 0. The read tap is the write pointer minus (D-1), modulo MAX_DELAY.
- Delay change: compared every enabled cycle. If eff_dly != o_DELAY:
  - o_DELAY <= eff_dly on that edge.
  - Settle counter loads eff_dly and o_SETTLED drops to 0 on the same edge.
- Settling:
  - Counter decrements each enabled cycle; o_SETTLED returns to 1 on the edge where the counter reaches 0.
  - While o_SETTLED=0, o_VALID=0. o_DATA still follows the new tap, but its contents are undefined-origin.
  - A new change during settling reloads the counter with the new eff_dly; there is no accumulation.
- o_VALID = raw delayed valid AND o_SETTLED, registered together with o_DATA.
- i_ENABLE=0: no write, pointer holds, outputs hold, settle counter holds, delay compare is suppressed (i_DELAY is ignored). Resuming continues seamlessly, so enable gaps stretch latency by their length.
- Stored valid bits: written every enabled cycle, including when i_VALID=0, so bubbles are preserved exactly.
- Simultaneous reset and delay change: reset wins.
- No combinational path from any input to any output.

Test Plan:
- Reset=0 for 3 cycles, then 1, with i_DELAY=4 held through reset.
  - During reset: o_DATA=0, o_VALID=0, o_DELAY=1, o_SETTLED=1.
  - Edge after release: o_DELAY=4, o_SETTLED=0. Settles after 4 edges.
  - Data 0x10.. driven from release appears 4 cycles later, valid only once settled.
- Fixed D=1, ramp 0x00..0x1F with i_VALID=1: o_DATA follows with one cycle lag. Repeat at D=16: lag of 16, with exact wrap across pointer 15->0.
- i_DELAY=0 -> o_DELAY=1; i_DELAY=31 (MAX_DELAY=16) -> o_DELAY=16. Latencies measured as 1 and 16.
- Delay change:
  - Switch D from 8 to 3 mid-stream: o_VALID low for exactly 3 cycles, then resumes with lag 3.
  - Switch 3 -> 12, then 12 -> 5 two cycles later: counter reloads, o_VALID low 5 cycles after the second change.
- D=6, i_VALID pattern 1,0,0,1,1,0: o_VALID reproduces the pattern 6 cycles later. Insert i_ENABLE=0 for 4 cycles mid-stream: outputs frozen, sequence intact, total lag 10.
- Assert Reset=0 for one cycle during settling: all outputs return to reset values and o_SETTLED=1. Post-reset behaviour matches the first scenario.
